bg_writer: RTL

- Write-side counterpart of the background drawer: fills the 12-bit-addressed background memory that the drawer reads, using a raster-ordered pixel stream.
- Accepts 12-bit RGB pixels over a valid/ready handshake, generates {y, x} write addresses in the same packing the drawer uses for reads, and drives a single write port.
- Optionally stalls writes outside vertical blanking to avoid tearing.
- Sits between the image source (UART/ROM loader) and the background RAM.

---
 rtl/bg_writer_if.sv | 22 ++
 rtl/bg_writer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bg_writer_if.sv
// bg_writer_if: raster pixel stream handshake.
// The source drives valid/data/last; the writer returns ready.
interface bg_writer_if;
    logic        pix_valid;
    logic [11:0] pix_data;
    logic        pix_last;
    logic        pix_ready;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/bg_writer.sv
// bg_writer: raster pixel stream to background RAM writer.
// Emits {y,x} addresses in the same packing the drawer reads.
module bg_writer #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter bit VBLNK_ONLY = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_vblnk,
    bg_writer_if.slave  s_pix,
    output logic        o_mem_we,
    output logic [11:0] o_mem_addr,
    output logic [11:0] o_mem_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH
    } state_t;

    localparam logic [5:0] X_MAX = 6'(IMG_W - 1);
    localparam logic [5:0] Y_MAX = 6'(IMG_H - 1);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_x;
    logic [5:0]  r_y;
    logic        r_err;
    logic        r_we;
    logic [11:0] r_addr;
    logic [11:0] r_data;
    logic        r_busy;
    logic        r_done;
    logic        w_ready;
    logic        w_xfer;
    logic        w_end_px;
    logic        w_go;

    assign w_end_px = (r_x == X_MAX) && (r_y == Y_MAX);
    assign w_go     = (r_state == S_IDLE) && i_start;
    assign w_xfer   = s_pix.pix_valid && w_ready;

    assign s_pix.pix_ready = w_ready;
    assign o_mem_we   = r_we;
    assign o_mem_addr = r_addr;
    assign o_mem_data = r_data;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and combinational ready
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready = VBLNK_ONLY ? i_vblnk : 1'b1;
                if (s_pix.pix_valid && w_ready &&
                    (w_end_px || s_pix.pix_last)) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Raster counters and sticky pix_last mismatch flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_err <= 1'b0;
        end else if (w_go) begin
            r_x   <= '0;
            r_y   <= '0;
            r_err <= 1'b0;
        end else if (w_xfer) begin
            if (r_x == X_MAX) begin
                r_x <= '0;
                r_y <= r_y + 6'd1;
            end else begin
                r_x <= r_x + 6'd1;
            end
            if (w_end_px != s_pix.pix_last) begin
                r_err <= 1'b1;
            end
        end
    end

    // Write port: one registered write per accepted pixel
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_xfer;
            if (w_xfer) begin
                r_addr <= {r_y, r_x};
                r_data <= s_pix.pix_data;
            end
        end
    end

    // Status: busy through FLUSH, done pulses in FLUSH
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_FLUSH);
        end
    end
endmodule
